// File: rtl/wdt_multi.sv
// wdt_multi: multi-channel windowed watchdog with keyed kicks, pre-timeout warning and sticky W1C timeout
//   clk, rst_n                          clock, asynchronous active-low reset
//   cfg_we, cfg_ch, cfg_timeout,
//   cfg_window, cfg_warn                per-channel threshold write (cfg_ch >= NCH ignored)
//   en                                  per-channel enable level
//   kick_valid, kick_ch, kick_key       single-ported keyed kick strobe
//   clr                                 per-channel W1C for the sticky timeout
//   wto, wto_any                        registered sticky timeout per channel and their OR
//   warn                                registered pre-timeout warning level
//   kick_err                            registered one-cycle pulse on a rejected kick
module wdt_multi #(
    parameter int NCH = 4,
    parameter int CNT_W = 32,
    parameter int KEY_W = 16,
    parameter logic [KEY_W-1:0] KICK_KEY = 16'hA55A,
    localparam int CW = NCH > 1 ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [CW-1:0]    cfg_ch,
    input  logic [CNT_W-1:0] cfg_timeout,
    input  logic [CNT_W-1:0] cfg_window,
    input  logic [CNT_W-1:0] cfg_warn,
    input  logic [NCH-1:0]   en,
    input  logic             kick_valid,
    input  logic [CW-1:0]    kick_ch,
    input  logic [KEY_W-1:0] kick_key,
    input  logic [NCH-1:0]   clr,
    output logic [NCH-1:0]   wto,
    output logic             wto_any,
    output logic [NCH-1:0]   warn,
    output logic [NCH-1:0]   kick_err
);
    typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_e;

    assign wto_any = |wto;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        state_e st_q, st_d;
        logic [CNT_W-1:0] cnt_q, cnt_d, to_q, win_q, wth_q;
        logic wto_q, wto_d, warn_q, warn_d, err_q, err_d;
        logic hit, key_ok, early, acc;
        assign hit = kick_valid && kick_ch == CW'(g);
        assign key_ok = kick_key == KICK_KEY;
        // a correctly keyed kick before the window opens is a violation, not a refresh
        assign early = hit && key_ok && win_q != '0 && cnt_q < win_q;
        assign acc = hit && key_ok && !early;
        always_comb begin
            st_d = st_q;
            cnt_d = cnt_q;
            wto_d = wto_q;
            err_d = 1'b0;
            if (st_q == IDLE) begin
                cnt_d = '0;
                st_d = en[g] ? RUN : IDLE;
            end else if (st_q == RUN) begin
                err_d = hit && !key_ok;
                // an accepted kick beats expiry; expiry beats disable
                if (cnt_q >= to_q && !acc) begin
                    st_d = EXPIRED;
                    wto_d = 1'b1;
                end else if (!en[g]) begin
                    st_d = IDLE;
                    cnt_d = '0;
                end else if (early) begin
                    st_d = EXPIRED;
                    wto_d = 1'b1;
                    err_d = 1'b1;
                end else if (acc) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = &cnt_q ? cnt_q : cnt_q + 1'b1;
                end
            end else if (clr[g]) begin
                wto_d = 1'b0;
                cnt_d = '0;
                st_d = en[g] ? RUN : IDLE;
            end
            // registered alongside count so it tracks the new count value
            warn_d = st_d == RUN && wth_q != '0 && cnt_d >= wth_q;
        end
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                st_q <= IDLE;
                cnt_q <= '0;
                to_q <= '1;
                win_q <= '0;
                wth_q <= '0;
                wto_q <= 1'b0;
                warn_q <= 1'b0;
                err_q <= 1'b0;
            end else begin
                st_q <= st_d;
                cnt_q <= cnt_d;
                wto_q <= wto_d;
                warn_q <= warn_d;
                err_q <= err_d;
                if (cfg_we && cfg_ch == CW'(g)) begin
                    to_q <= cfg_timeout;
                    win_q <= cfg_window;
                    wth_q <= cfg_warn;
                end
            end
        end
        assign wto[g] = wto_q;
        assign warn[g] = warn_q;
        assign kick_err[g] = err_q;
    end
endmodule

// File: tb/tb_wdt_multi.sv
// tb_wdt_multi: directed self-checking bench for wdt_multi (NCH=4 main instance, NCH=3 out-of-range instance)
module tb_wdt_multi;
    localparam logic [15:0] KEY = 16'hA55A;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cfg_we, kick_valid, wto_any;
    logic [1:0] cfg_ch, kick_ch;
    logic [31:0] cfg_timeout, cfg_window, cfg_warn;
    logic [15:0] kick_key;
    logic [3:0] en, clr, wto, warn, kick_err;
    logic cfg_we3, kick_valid3, wto_any3;
    logic [1:0] cfg_ch3, kick_ch3;
    logic [2:0] en3, clr3, wto3, warn3, kick_err3;
    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    wdt_multi #(.NCH(4)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_timeout(cfg_timeout), .cfg_window(cfg_window), .cfg_warn(cfg_warn),
        .en(en), .kick_valid(kick_valid), .kick_ch(kick_ch), .kick_key(kick_key),
        .clr(clr), .wto(wto), .wto_any(wto_any), .warn(warn), .kick_err(kick_err)
    );

    wdt_multi #(.NCH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we3), .cfg_ch(cfg_ch3),
        .cfg_timeout(cfg_timeout), .cfg_window(cfg_window), .cfg_warn(cfg_warn),
        .en(en3), .kick_valid(kick_valid3), .kick_ch(kick_ch3), .kick_key(kick_key),
        .clr(clr3), .wto(wto3), .wto_any(wto_any3), .warn(warn3), .kick_err(kick_err3)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [1:0] ch, input logic [31:0] t, input logic [31:0] w, input logic [31:0] h);
        cfg_we = 1'b1;
        cfg_ch = ch;
        cfg_timeout = t;
        cfg_window = w;
        cfg_warn = h;
        tick;
        cfg_we = 1'b0;
    endtask

    task automatic cfg3(input logic [1:0] ch, input logic [31:0] t, input logic [31:0] w, input logic [31:0] h);
        cfg_we3 = 1'b1;
        cfg_ch3 = ch;
        cfg_timeout = t;
        cfg_window = w;
        cfg_warn = h;
        tick;
        cfg_we3 = 1'b0;
    endtask

    task automatic kick(input logic [1:0] ch, input logic [15:0] k);
        kick_valid = 1'b1;
        kick_ch = ch;
        kick_key = k;
        tick;
        kick_valid = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) tick;
        vecs++; if (wto !== 4'b0) begin errs++; $display("FAIL reset_wto got=%b exp=0000", wto); end
        vecs++; if (warn !== 4'b0) begin errs++; $display("FAIL reset_warn got=%b exp=0000", warn); end
        vecs++; if (kick_err !== 4'b0) begin errs++; $display("FAIL reset_kerr got=%b exp=0000", kick_err); end
        vecs++; if (wto_any !== 1'b0) begin errs++; $display("FAIL reset_any got=%b exp=0", wto_any); end
        vecs++; if (wto3 !== 3'b0) begin errs++; $display("FAIL reset_wto3 got=%b exp=000", wto3); end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_expiry;
        cfg(2'd0, 32'd5, 32'd0, 32'd0);
        en[0] = 1'b1;
        for (int n = 0; n <= 8; n++) begin
            tick;
            vecs++; if (wto !== ((n >= 6) ? 4'b0001 : 4'b0000)) begin errs++; $display("FAIL expiry_wto n=%0d got=%b exp=%b", n, wto, (n >= 6) ? 4'b0001 : 4'b0000); end
            vecs++; if (wto_any !== (n >= 6)) begin errs++; $display("FAIL expiry_any n=%0d got=%b exp=%b", n, wto_any, n >= 6); end
        end
        en[0] = 1'b0;
        clr[0] = 1'b1;
        tick;
        clr[0] = 1'b0;
        vecs++; if (wto !== 4'b0) begin errs++; $display("FAIL expiry_clr got=%b exp=0000", wto); end
    endtask

    task automatic test_kicks;
        cfg(2'd1, 32'd10, 32'd0, 32'd0);
        en[1] = 1'b1;
        tick;
        for (int n = 1; n <= 100; n++) begin
            kick_valid = (n % 8 == 0);
            kick_ch = 2'd1;
            kick_key = KEY;
            tick;
            kick_valid = 1'b0;
            vecs++; if (wto[1] !== 1'b0) begin errs++; $display("FAIL kicks_wto n=%0d got=%b exp=0", n, wto[1]); end
            vecs++; if (kick_err[1] !== 1'b0) begin errs++; $display("FAIL kicks_err n=%0d got=%b exp=0", n, kick_err[1]); end
        end
        kick(2'd1, KEY);
        repeat (3) tick;
        kick(2'd1, 16'h1234);
        vecs++; if (kick_err !== 4'b0010) begin errs++; $display("FAIL badkey_err got=%b exp=0010", kick_err); end
        vecs++; if (wto !== 4'b0) begin errs++; $display("FAIL badkey_wto got=%b exp=0000", wto); end
        tick;
        vecs++; if (kick_err !== 4'b0) begin errs++; $display("FAIL badkey_pulse got=%b exp=0000", kick_err); end
        repeat (5) tick;
        vecs++; if (wto[1] !== 1'b0) begin errs++; $display("FAIL badkey_early_exp got=%b exp=0", wto[1]); end
        tick;
        vecs++; if (wto[1] !== 1'b1) begin errs++; $display("FAIL badkey_exp got=%b exp=1", wto[1]); end
        en[1] = 1'b0;
        clr[1] = 1'b1;
        tick;
        clr[1] = 1'b0;
    endtask

    task automatic test_window;
        cfg(2'd2, 32'd10, 32'd4, 32'd0);
        en[2] = 1'b1;
        tick;
        repeat (2) tick;
        kick(2'd2, KEY);
        vecs++; if (kick_err !== 4'b0100) begin errs++; $display("FAIL win_early_err got=%b exp=0100", kick_err); end
        vecs++; if (wto !== 4'b0100) begin errs++; $display("FAIL win_early_wto got=%b exp=0100", wto); end
        tick;
        vecs++; if (kick_err !== 4'b0) begin errs++; $display("FAIL win_err_pulse got=%b exp=0000", kick_err); end
        vecs++; if (wto !== 4'b0100) begin errs++; $display("FAIL win_sticky got=%b exp=0100", wto); end
        clr[2] = 1'b1;
        tick;
        clr[2] = 1'b0;
        vecs++; if (wto !== 4'b0) begin errs++; $display("FAIL win_clr got=%b exp=0000", wto); end
        repeat (4) tick;
        kick(2'd2, KEY);
        vecs++; if (kick_err !== 4'b0) begin errs++; $display("FAIL win_ok_err got=%b exp=0000", kick_err); end
        vecs++; if (wto !== 4'b0) begin errs++; $display("FAIL win_ok_wto got=%b exp=0000", wto); end
        repeat (10) tick;
        vecs++; if (wto[2] !== 1'b0) begin errs++; $display("FAIL win_restart_pre got=%b exp=0", wto[2]); end
        tick;
        vecs++; if (wto[2] !== 1'b1) begin errs++; $display("FAIL win_restart_exp got=%b exp=1", wto[2]); end
        en[2] = 1'b0;
        clr[2] = 1'b1;
        tick;
        clr[2] = 1'b0;
    endtask

    task automatic test_warn_clear;
        cfg(2'd3, 32'd9, 32'd0, 32'd7);
        en[3] = 1'b1;
        tick;
        for (int n = 1; n <= 11; n++) begin
            tick;
            vecs++; if (warn[3] !== (n >= 7 && n <= 9)) begin errs++; $display("FAIL warn_lvl n=%0d got=%b exp=%b", n, warn[3], n >= 7 && n <= 9); end
            vecs++; if (wto[3] !== (n >= 10)) begin errs++; $display("FAIL warn_wto n=%0d got=%b exp=%b", n, wto[3], n >= 10); end
        end
        clr[3] = 1'b1;
        tick;
        clr[3] = 1'b0;
        vecs++; if (wto[3] !== 1'b0) begin errs++; $display("FAIL clr_run_wto got=%b exp=0", wto[3]); end
        vecs++; if (warn[3] !== 1'b0) begin errs++; $display("FAIL clr_run_warn got=%b exp=0", warn[3]); end
        for (int n = 1; n <= 10; n++) begin
            tick;
            vecs++; if (warn[3] !== (n >= 7 && n <= 9)) begin errs++; $display("FAIL rewarn n=%0d got=%b exp=%b", n, warn[3], n >= 7 && n <= 9); end
            vecs++; if (wto[3] !== (n == 10)) begin errs++; $display("FAIL rewto n=%0d got=%b exp=%b", n, wto[3], n == 10); end
        end
        en[3] = 1'b0;
        clr[3] = 1'b1;
        tick;
        clr[3] = 1'b0;
        vecs++; if (wto !== 4'b0) begin errs++; $display("FAIL clr_idle got=%b exp=0000", wto); end
    endtask

    task automatic test_kick_at_timeout;
        cfg(2'd1, 32'd6, 32'd0, 32'd0);
        en[1] = 1'b1;
        tick;
        repeat (6) tick;
        vecs++; if (wto[1] !== 1'b0) begin errs++; $display("FAIL kat_pre got=%b exp=0", wto[1]); end
        kick(2'd1, KEY);
        vecs++; if (wto[1] !== 1'b0) begin errs++; $display("FAIL kat_wto got=%b exp=0", wto[1]); end
        vecs++; if (kick_err !== 4'b0) begin errs++; $display("FAIL kat_err got=%b exp=0000", kick_err); end
        repeat (6) tick;
        vecs++; if (wto[1] !== 1'b0) begin errs++; $display("FAIL kat_hold got=%b exp=0", wto[1]); end
        tick;
        vecs++; if (wto[1] !== 1'b1) begin errs++; $display("FAIL kat_exp got=%b exp=1", wto[1]); end
        en[1] = 1'b0;
        clr[1] = 1'b1;
        tick;
        clr[1] = 1'b0;
    endtask

    task automatic test_cfg_lower;
        cfg(2'd0, 32'd100, 32'd0, 32'd0);
        en[0] = 1'b1;
        tick;
        repeat (10) tick;
        cfg(2'd0, 32'd5, 32'd0, 32'd0);
        vecs++; if (wto[0] !== 1'b0) begin errs++; $display("FAIL lower_pre got=%b exp=0", wto[0]); end
        tick;
        vecs++; if (wto[0] !== 1'b1) begin errs++; $display("FAIL lower_exp got=%b exp=1", wto[0]); end
        en[0] = 1'b0;
        clr[0] = 1'b1;
        tick;
        clr[0] = 1'b0;
    endtask

    task automatic test_out_of_range;
        cfg3(2'd3, 32'd2, 32'd0, 32'd0);
        cfg3(2'd0, 32'd4, 32'd0, 32'd0);
        en3 = 3'b111;
        tick;
        for (int n = 1; n <= 6; n++) begin
            kick_valid3 = 1'b1;
            kick_ch3 = 2'd3;
            kick_key = (n % 2 == 1) ? 16'h1234 : KEY;
            tick;
            kick_valid3 = 1'b0;
            vecs++; if (kick_err3 !== 3'b0) begin errs++; $display("FAIL oor_err n=%0d got=%b exp=000", n, kick_err3); end
            vecs++; if (wto3 !== ((n >= 5) ? 3'b001 : 3'b000)) begin errs++; $display("FAIL oor_wto n=%0d got=%b exp=%b", n, wto3, (n >= 5) ? 3'b001 : 3'b000); end
        end
        en3 = 3'b000;
        for (int n = 0; n < 3; n++) begin
            tick;
            vecs++; if (wto3 !== 3'b001) begin errs++; $display("FAIL dis_sticky n=%0d got=%b exp=001", n, wto3); end
        end
        clr3 = 3'b001;
        tick;
        clr3 = 3'b000;
        vecs++; if (wto3 !== 3'b0) begin errs++; $display("FAIL dis_clr got=%b exp=000", wto3); end
        vecs++; if (wto_any3 !== 1'b0) begin errs++; $display("FAIL dis_any got=%b exp=0", wto_any3); end
    endtask

    task automatic test_async_reset;
        cfg(2'd0, 32'd20, 32'd0, 32'd2);
        cfg(2'd3, 32'd0, 32'd0, 32'd0);
        en = 4'b1001;
        tick;
        vecs++; if (wto !== 4'b0) begin errs++; $display("FAIL t0_pre got=%b exp=0000", wto); end
        tick;
        vecs++; if (wto !== 4'b1000) begin errs++; $display("FAIL t0_exp got=%b exp=1000", wto); end
        vecs++; if (wto_any !== 1'b1) begin errs++; $display("FAIL t0_any got=%b exp=1", wto_any); end
        repeat (3) tick;
        vecs++; if (warn !== 4'b0001) begin errs++; $display("FAIL ar_warn_pre got=%b exp=0001", warn); end
        #2 rst_n = 1'b0;
        #1;
        vecs++; if (wto !== 4'b0) begin errs++; $display("FAIL ar_wto got=%b exp=0000", wto); end
        vecs++; if (warn !== 4'b0) begin errs++; $display("FAIL ar_warn got=%b exp=0000", warn); end
        vecs++; if (wto_any !== 1'b0) begin errs++; $display("FAIL ar_any got=%b exp=0", wto_any); end
        en = 4'b0;
        tick;
        rst_n = 1'b1;
        tick;
        vecs++; if ({wto, warn, kick_err} !== 12'b0) begin errs++; $display("FAIL ar_release got=%b exp=0", {wto, warn, kick_err}); end
    endtask

    initial begin
        cfg_we = 1'b0; cfg_ch = 2'd0; cfg_timeout = '0; cfg_window = '0; cfg_warn = '0;
        en = '0; clr = '0; kick_valid = 1'b0; kick_ch = 2'd0; kick_key = '0;
        cfg_we3 = 1'b0; cfg_ch3 = 2'd0; en3 = '0; clr3 = '0; kick_valid3 = 1'b0; kick_ch3 = 2'd0;
        test_reset;
        test_expiry;
        test_kicks;
        test_window;
        test_warn_clear;
        test_kick_at_timeout;
        test_cfg_lower;
        test_out_of_range;
        test_async_reset;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/wdt_multi.md
# wdt_multi

Multi-channel, parametrised watchdog timer on a single clock domain. It is the next-generation watchdog for the peripheral subsystem and replaces the single-channel, single-mode timer. It adds per-channel configuration, windowed kicking, keyed kick protection, a pre-timeout warning and a W1C sticky timeout status. All channels share one clock and one configuration/kick bus. Outputs feed the interrupt controller (`warn`) and the reset/CPU-interrupt logic (`wto_any`).

## Interface
- `NCH`, default 4: number of independent watchdog channels (1..16).
- `CNT_W`, default 32: counter and threshold width.
- `KEY_W`, default 16: kick key width.
- `KICK_KEY`, default 16'hA55A: the only kick key value accepted.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cfg_we`  in  1  write the three threshold registers of channel `cfg_ch`.
- `cfg_ch`  in  $clog2(NCH) (min 1)  channel selected for a config write.
- `cfg_timeout`  in  CNT_W  expiry threshold.
- `cfg_window`  in  CNT_W  window-open threshold; 0 disables window mode.
- `cfg_warn`  in  CNT_W  warning threshold; 0 disables the warning.
- `en`  in  NCH  per-channel enable, level.
- `kick_valid`  in  1  kick strobe, one cycle.
- `kick_ch`  in  $clog2(NCH)  channel being kicked.
- `kick_key`  in  KEY_W  key accompanying the kick.
- `clr`  in  NCH  per-channel W1C pulse for the sticky timeout.
- `wto`  out  NCH  sticky timeout per channel, registered.
- `wto_any`  out  1  OR of `wto`.
- `warn`  out  NCH  pre-timeout warning level, registered.
- `kick_err`  out  NCH  one-cycle pulse on a rejected kick, registered.

## Operation
- **Per-channel state:** IDLE, RUN or EXPIRED, plus a `CNT_W`-bit `count` and three config registers.
- **Reset values:**
  - `count` = 0; state IDLE.
  - `timeout` = all-ones; `window` = 0; `warn_th` = 0.
  - All outputs 0.
- **Config write:** `cfg_we` writes the registers of `cfg_ch` only. A `cfg_ch` ≥ NCH is ignored. New values apply from the next cycle, and the count is not touched.
- **IDLE:**
  - `count` = 0.
  - `en[i]`=1 → RUN with `count`=0.
- **RUN:**
  - `en[i]`=0 → IDLE and `count`=0. This has priority over everything except `count >= timeout` evaluated in the same cycle.
  - `count >= timeout` → EXPIRED, `wto[i]`=1, `count` holds.
  - Otherwise `count` increments by 1. The increment saturates at all-ones and never wraps.
- **Valid kick:** `kick_valid` and `kick_ch`==i while in RUN.
  - Key ≠ `KICK_KEY` → `kick_err[i]` pulse; count unaffected; no timeout.
  - Key OK, `window`≠0 and `count < window` → early kick. `kick_err[i]` pulse, `wto[i]`=1, state EXPIRED.
  - Key OK otherwise → `count`=0.
- **Kick vs expiry in the same cycle:** an accepted kick wins, so `count`=0 and there is no expiry.
- **Kicks outside RUN:** a kick to a channel in IDLE or EXPIRED is ignored, with no error. A kick with `kick_ch` ≥ NCH is ignored.
- **EXPIRED:**
  - `count` holds; `wto[i]` stays 1 regardless of `en[i]`.
  - `clr[i]`=1 → `wto[i]`=0. The channel goes to RUN with `count`=0 if `en[i]`=1, otherwise to IDLE.
  - `clr[i]` in IDLE or RUN has no effect.
- **`warn[i]`:** = 1 when state RUN, `warn_th`≠0 and `count >= warn_th`. It is 0 in IDLE and EXPIRED.
- **`wto_any`:** combinational OR of the registered `wto`, so it is glitch-free.
- **Comparisons:** all unsigned, `CNT_W` bits.

## Timing
- **Enable to first count:** `en` rising at edge k puts the channel in RUN with `count`=0 after edge k. `count`=n after edge k+n.
- **Expiry latency:** with `timeout`=T and no kicks, `wto` rises after edge k+T+1. T=0 expires after edge k+1.
- **Kick latency:** a kick sampled at edge m gives `count`=0 after edge m. `kick_err` is high exactly for the cycle after edge m.
- **`warn` latency:** rises in the same cycle `count` first satisfies the threshold (registered alongside `count`). It falls with the kick or the expiry edge.
- **Clear latency:** `clr` sampled at edge c → `wto`=0 after edge c.
- **Asynchronous reset:** `rst_n` low forces every channel to its reset values immediately, mid-count or EXPIRED included. Release is sampled on the next rising `clk` edge.
- **Kicks per cycle:** at most one, since `kick_ch` is single-ported.

## Test plan
- **Reset and expiry:** reset, ch0 `timeout`=5, `en[0]`=1, no kicks → `wto[0]`/`wto_any` rise 6 cycles after enable. `count` holds at 5. Other channels stay 0.
- **Valid kicks:** ch1 `timeout`=10, kick with key A55A every 8 cycles for 100 cycles → `wto[1]` never set, `kick_err[1]` never pulses. Kick with key 1234 → `kick_err[1]` one-cycle pulse, count keeps running, expiry at the original cycle.
- **Window mode:** ch2 `window`=4, `timeout`=10.
  - Kick at `count`=2 → `kick_err[2]` pulse and `wto[2]`=1 next cycle.
  - Kick at `count`=4 → count resets, no error.
- **Warning and clear:** ch3 `warn_th`=7, `timeout`=9 → `warn[3]` high for `count`=7..9 and 0 after expiry. `clr[3]` with `en[3]`=1 → `wto[3]`=0, count restarts at 0. `clr[3]` with `en[3]`=0 → IDLE.
- **Simultaneous and mid-operation events:**
  - Accepted kick in the cycle `count`==`timeout` → no expiry.
  - `rst_n` asserted mid-count → all outputs 0 immediately.
  - `cfg_timeout` lowered below the current count while in RUN → expiry on the next cycle.
- **Out-of-range and disable:** `kick_ch`/`cfg_ch` = NCH (NCH=3 build) → no state change. `en` dropped in EXPIRED → `wto` stays 1 until `clr`.
